// File: rtl/dot_acc_pkg.sv
// Shared types and helpers for the pipelined dot-product accumulator.
// Width helpers keep derived widths consistent between the top and its sub-blocks.
package dot_acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    function automatic int unsigned prod_width(input int unsigned in_w);
        return 2 * in_w;
    endfunction

    function automatic int unsigned sum_width(input int unsigned in_w, input int unsigned lanes);
        return 2 * in_w + $clog2(lanes);
    endfunction

    // Signed: like-signed operands giving an opposite-signed result. Unsigned: carry out.
    function automatic logic acc_overflow(input logic is_signed, input logic a_msb,
                                          input logic b_msb, input logic r_msb,
                                          input logic carry);
        if (is_signed) begin
            return (a_msb == b_msb) && (r_msb != a_msb);
        end
        return carry;
    endfunction

endpackage

// File: rtl/dot_adder_tree.sv
// Combinational binary adder tree over LANES packed operands.
// Leaves are sign- or zero-extended to the output width, so every level is a plain add.
module dot_adder_tree #(
    parameter int unsigned LANES = 4,
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = IN_W + $clog2(LANES)
) (
    input  logic [LANES*IN_W-1:0] operands,
    input  logic                  is_signed,
    output logic [OUT_W-1:0]      sum
);

    localparam int unsigned LEVELS = $clog2(LANES);

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned N = LANES >> l;
        logic [OUT_W-1:0] node [N];

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_i
                logic signed [IN_W:0] leaf_ext;
                assign leaf_ext = {is_signed & operands[i*IN_W+IN_W-1], operands[i*IN_W +: IN_W]};
                assign node[i]  = OUT_W'(leaf_ext);
            end
        end else begin : g_add
            for (genvar i = 0; i < N; i++) begin : g_i
                assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
            end
        end
    end

    assign sum = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/dot_acc_unit.sv
// Three-stage dot-product unit: lane multiply, adder-tree reduce, group accumulate.
// A single global enable stalls every stage while the output register is held.
module dot_acc_unit
    import dot_acc_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 48,
    parameter int unsigned TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] in_a,
    input  logic [LANES*IN_W-1:0] in_b,
    input  logic [LANES-1:0]      in_mask,
    input  logic                  in_signed,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_result,
    output logic                  out_overflow,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  busy
);

    localparam int unsigned PROD_W = prod_width(IN_W);
    localparam int unsigned SUM_W  = sum_width(IN_W, LANES);

    if (ACC_W < SUM_W) begin : g_acc_w_check
        $error("dot_acc_unit: ACC_W too narrow for LANES/IN_W");
    end
    if (LANES == 0 || (LANES & (LANES - 1)) != 0) begin : g_lanes_check
        $error("dot_acc_unit: LANES must be a power of two");
    end

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    function automatic logic [PROD_W-1:0] lane_mul(input logic [IN_W-1:0] a,
                                                   input logic [IN_W-1:0] b,
                                                   input logic sgn);
        logic signed [IN_W:0]   xa;
        logic signed [IN_W:0]   xb;
        logic signed [PROD_W-1:0] ea;
        logic signed [PROD_W-1:0] eb;
        xa = {sgn & a[IN_W-1], a};
        xb = {sgn & b[IN_W-1], b};
        ea = PROD_W'(xa);
        eb = PROD_W'(xb);
        return ea * eb;
    endfunction

    // S1: lane products
    logic [LANES*PROD_W-1:0] prod_d;
    logic [LANES*PROD_W-1:0] s1_prod;
    logic                    s1_valid, s1_signed, s1_first, s1_last;
    logic [TAG_W-1:0]        s1_tag;

    always_comb begin
        prod_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_mask[i]) begin
                prod_d[i*PROD_W +: PROD_W] = lane_mul(in_a[i*IN_W +: IN_W],
                                                      in_b[i*IN_W +: IN_W], in_signed);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_signed <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_tag    <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_prod   <= prod_d;
            s1_signed <= in_signed;
            s1_first  <= in_first;
            s1_last   <= in_last;
            s1_tag    <= in_tag;
        end
    end

    // S2: reduction
    logic [SUM_W-1:0] tree_sum;
    logic [SUM_W-1:0] s2_sum;
    logic             s2_valid, s2_signed, s2_first, s2_last;
    logic [TAG_W-1:0] s2_tag;

    dot_adder_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W),
        .OUT_W (SUM_W)
    ) u_tree (
        .operands  (s1_prod),
        .is_signed (s1_signed),
        .sum       (tree_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_sum    <= '0;
            s2_signed <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_tag    <= '0;
        end else if (en) begin
            s2_valid  <= s1_valid;
            s2_sum    <= tree_sum;
            s2_signed <= s1_signed;
            s2_first  <= s1_first;
            s2_last   <= s1_last;
            s2_tag    <= s1_tag;
        end
    end

    // S3: accumulate; a group restarts from zero in IDLE or on a first beat
    acc_state_e       state_q;
    logic [ACC_W-1:0] acc_q;
    logic             ov_q;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_full;
    logic             start;
    logic             ov_now;
    logic             ov_next;

    always_comb begin
        sum_ext  = ACC_W'($signed({s2_signed & s2_sum[SUM_W-1], s2_sum}));
        start    = (state_q == IDLE) || s2_first;
        acc_base = start ? '0 : acc_q;
        acc_full = {1'b0, acc_base} + {1'b0, sum_ext};
        ov_now   = acc_overflow(s2_signed, acc_base[ACC_W-1], sum_ext[ACC_W-1],
                                acc_full[ACC_W-1], acc_full[ACC_W]);
        ov_next  = (!start && ov_q) || ov_now;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            ov_q         <= 1'b0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_tag      <= '0;
        end else if (en) begin
            out_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    out_result   <= acc_full[ACC_W-1:0];
                    out_overflow <= ov_next;
                    out_tag      <= s2_tag;
                    state_q      <= IDLE;
                    acc_q        <= '0;
                    ov_q         <= 1'b0;
                end else begin
                    acc_q   <= acc_full[ACC_W-1:0];
                    ov_q    <= ov_next;
                    state_q <= ACCUM;
                end
            end
        end
    end

    assign busy = s1_valid || s2_valid || out_valid || (state_q == ACCUM);

endmodule

// File: tb/tb_dot_acc_unit.sv
// Directed bench for dot_acc_unit: a default 48-bit instance and a 36-bit instance
// share stimulus; results are collected per instance and compared to hand-computed values.
module tb_dot_acc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic [3:0]  in_mask = '0;
    logic        in_signed = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_overflow, busy;
    logic [47:0] out_result;
    logic [3:0]  out_tag;
    logic        in_ready_b, out_valid_b, out_overflow_b, busy_b;
    logic [35:0] out_result_b;
    logic [3:0]  out_tag_b;

    always #5 clk = ~clk;

    dot_acc_unit #(.LANES(4), .IN_W(16), .ACC_W(48), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_signed(in_signed),
        .in_first(in_first), .in_last(in_last), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_tag(out_tag), .busy(busy)
    );

    dot_acc_unit #(.LANES(4), .IN_W(16), .ACC_W(36), .TAG_W(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_signed(in_signed),
        .in_first(in_first), .in_last(in_last), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_result(out_result_b),
        .out_overflow(out_overflow_b), .out_tag(out_tag_b), .busy(busy_b)
    );

    logic [47:0] res_a[$];
    logic [3:0]  tag_a[$];
    logic        ov_a[$];
    logic [35:0] res_b[$];
    logic [3:0]  tag_b[$];
    logic        ov_b[$];

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            res_a.push_back(out_result);
            tag_a.push_back(out_tag);
            ov_a.push_back(out_overflow);
        end
        if (out_valid_b && out_ready) begin
            res_b.push_back(out_result_b);
            tag_b.push_back(out_tag_b);
            ov_b.push_back(out_overflow_b);
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic logic [63:0] p4(input logic [15:0] x0, input logic [15:0] x1,
                                       input logic [15:0] x2, input logic [15:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic [3:0] mask,
                        input logic sgn, input logic first, input logic last,
                        input logic [3:0] tag);
        int n = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_mask   = mask;
        in_signed = sgn;
        in_first  = first;
        in_last   = last;
        in_tag    = tag;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_a(input string name, input logic [47:0] r, input logic [3:0] t,
                            input logic o);
        int n = 0;
        while (res_a.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_avail"}, 64'(res_a.size() != 0), 64'd1);
        if (res_a.size() != 0) begin
            check({name, "_result"}, 64'(res_a.pop_front()), 64'(r));
            check({name, "_tag"}, 64'(tag_a.pop_front()), 64'(t));
            check({name, "_ovf"}, 64'(ov_a.pop_front()), 64'(o));
        end
    endtask

    task automatic expect_b(input string name, input logic [35:0] r, input logic [3:0] t,
                            input logic o);
        int n = 0;
        while (res_b.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_avail"}, 64'(res_b.size() != 0), 64'd1);
        if (res_b.size() != 0) begin
            check({name, "_result"}, 64'(res_b.pop_front()), 64'(r));
            check({name, "_tag"}, 64'(tag_b.pop_front()), 64'(t));
            check({name, "_ovf"}, 64'(ov_b.pop_front()), 64'(o));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_ovf", 64'(out_overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single-beat group and its latency
        beat(p4(1, 2, 3, 4), p4(5, 6, 7, 8), 4'hF, 1'b1, 1'b1, 1'b1, 4'd3);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_lat2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_lat3", 64'(out_valid), 64'd1);
        expect_a("t1", 48'd70, 4'd3, 1'b0);

        // Three-beat group
        beat(p4(1, 1, 1, 1), p4(2, 2, 2, 2), 4'hF, 1'b1, 1'b1, 1'b0, 4'd1);
        beat(p4(1, 1, 1, 1), p4(2, 2, 2, 2), 4'hF, 1'b1, 1'b0, 1'b0, 4'd2);
        beat(p4(1, 1, 1, 1), p4(2, 2, 2, 2), 4'hF, 1'b1, 1'b0, 1'b1, 4'd7);
        idle(6);
        check("t2_count", 64'(res_a.size()), 64'd1);
        expect_a("t2", 48'd24, 4'd7, 1'b0);

        // Signed vs unsigned interpretation of 16'hFFFF
        beat({4{16'hFFFF}}, p4(2, 2, 2, 2), 4'hF, 1'b1, 1'b1, 1'b1, 4'd4);
        beat({4{16'hFFFF}}, p4(2, 2, 2, 2), 4'hF, 1'b0, 1'b1, 1'b1, 4'd5);
        idle(4);
        expect_a("t3_signed", 48'hFFFF_FFFF_FFF8, 4'd4, 1'b0);
        expect_a("t3_unsigned", 48'd524280, 4'd5, 1'b0);

        // Masking, then a restart that drops a partial 100
        beat(p4(10, 20, 30, 40), p4(1, 1, 1, 1), 4'b0101, 1'b1, 1'b1, 1'b1, 4'd6);
        beat(p4(25, 25, 25, 25), p4(1, 1, 1, 1), 4'hF, 1'b1, 1'b1, 1'b0, 4'd8);
        beat(p4(1, 2, 3, 4), p4(5, 6, 7, 8), 4'hF, 1'b1, 1'b1, 1'b0, 4'd9);
        beat(p4(1, 1, 1, 1), p4(2, 2, 2, 2), 4'hF, 1'b1, 1'b0, 1'b1, 4'd10);
        idle(4);
        expect_a("t4_mask", 48'd40, 4'd6, 1'b0);
        expect_a("t4_restart", 48'd78, 4'd10, 1'b0);

        // Backpressure: hold the consumer off while three groups stream in
        out_ready = 1'b0;
        beat(p4(1, 2, 3, 4), p4(5, 6, 7, 8), 4'hF, 1'b1, 1'b1, 1'b1, 4'd1);
        beat(p4(3, 3, 3, 3), p4(2, 2, 2, 2), 4'hF, 1'b1, 1'b1, 1'b1, 4'd2);
        beat(p4(10, 20, 30, 40), p4(1, 1, 1, 1), 4'b0101, 1'b1, 1'b1, 1'b1, 4'd3);
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t5_hold_valid", 64'(out_valid), 64'd1);
            check("t5_hold_result", 64'(out_result), 64'd70);
        end
        check("t5_in_ready", 64'(in_ready), 64'd0);
        check("t5_in_ready_b", 64'(in_ready_b), 64'd0);
        check("t5_none_taken", 64'(res_a.size()), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        expect_a("t5_r0", 48'd70, 4'd1, 1'b0);
        expect_a("t5_r1", 48'd24, 4'd2, 1'b0);
        expect_a("t5_r2", 48'd40, 4'd3, 1'b0);

        // Long unsigned group: wraps the 36-bit accumulator, not the 48-bit one
        res_b.delete();
        tag_b.delete();
        ov_b.delete();
        for (int i = 0; i < 16; i++) begin
            beat({4{16'hFFFF}}, {4{16'hFFFF}}, 4'hF, 1'b0, 1'(i == 0), 1'(i == 15),
                 (i == 15) ? 4'd12 : 4'd0);
        end
        idle(4);
        expect_b("t6_acc36", 36'hF_FF80_0040, 4'd12, 1'b1);
        expect_a("t6_acc48", 48'h3F_FF80_0040, 4'd12, 1'b0);

        // Reset in the middle of a group
        res_b.delete();
        tag_b.delete();
        ov_b.delete();
        beat(p4(1, 2, 3, 4), p4(5, 6, 7, 8), 4'hF, 1'b1, 1'b1, 1'b0, 4'd1);
        beat(p4(1, 2, 3, 4), p4(5, 6, 7, 8), 4'hF, 1'b1, 1'b0, 1'b0, 4'd1);
        in_valid = 1'b0;
        check("t7_busy_open", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t7_rst_valid", 64'(out_valid), 64'd0);
        check("t7_rst_busy", 64'(busy), 64'd0);
        check("t7_rst_busy_b", 64'(busy_b), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(5);
        check("t7_no_result", 64'(res_a.size()), 64'd0);
        check("t7_idle_busy", 64'(busy), 64'd0);
        beat(p4(1, 2, 3, 4), p4(5, 6, 7, 8), 4'hF, 1'b1, 1'b1, 1'b1, 4'd9);
        idle(4);
        expect_a("t7_after", 48'd70, 4'd9, 1'b0);
        expect_b("t7_after_b", 36'd70, 4'd9, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_acc_unit.md
Name: dot_acc_unit

Overview:
- Parametrised, pipelined N-lane integer dot-product unit with multi-beat accumulation for the tensor datapath.
- Each accepted beat multiplies LANES pairs, reduces them through an adder tree, and adds the sum into a group accumulator.
- A group is delimited by first/last flags. One result per group is emitted on a valid/ready output, with a sticky overflow flag.
- Successor to the single-FMA dot unit: adds lane-count generalisation, masking, signed/unsigned mode, accumulation and backpressure.

Parameters:
- LANES, 4, number of multiply lanes; power of two, >= 1.
- IN_W, 16, operand width per lane.
- ACC_W, 48, accumulator and result width; must be >= 2*IN_W + clog2(LANES) (elaboration-time assertion).
- TAG_W, 4, width of the opaque tag carried with each group.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_a  in  LANES*IN_W  operand A; lane i at bits [i*IN_W +: IN_W]
- in_b  in  LANES*IN_W  operand B, same packing as in_a
- in_mask  in  LANES  lane enable; masked lane contributes 0
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_first  in  1  beat starts a new group
- in_last  in  1  beat closes the group
- in_tag  in  TAG_W  tag; value sampled on the last beat is returned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  ACC_W  group sum, modulo 2^ACC_W
- out_overflow  out  1  set if any accumulate in the group overflowed
- out_tag  out  TAG_W  tag of the group's last beat
- busy  out  1  any pipeline stage valid or accumulation group open

Behaviour:
- Reset (async, active-high): all stage valids 0, accumulator 0, overflow flag 0, FSM to IDLE. Outputs out_valid=0, out_result=0, out_overflow=0, out_tag=0, busy=0.
- Global stall: en = !out_valid || out_ready, and in_ready = en. On stall every stage holds; no beat is lost or duplicated.
- S1 (multiply): per-lane product of width 2*IN_W, registered. Masked lane = 0. Extension uses the beat's own in_signed.
- S2 (reduce): adder tree of width 2*IN_W + clog2(LANES), registered. The tree is combinational inside the stage.
- S3 (accumulate): sum is sign- or zero-extended to ACC_W and added to acc, unless the beat starts a group, in which case acc = sum.
- Latency: last beat accepted at cycle t gives out_valid=1 at t+3 with no stall. Throughput is 1 beat/cycle.
- Accumulator FSM:
  - IDLE: any beat starts a group, whether or not in_first is set; enters ACCUM unless the beat has in_last.
  - ACCUM: a beat with in_first abandons the partial sum and restarts (acc = sum, overflow cleared).
  - A beat with in_last loads the output register (acc+sum, tag, overflow) and returns the FSM to IDLE.
  - first && last together: single-beat group.
- Overflow:
  - Signed: operands of the same sign and a result sign that differs.
  - Unsigned: carry out of ACC_W.
  - The flag is sticky within the group and cleared at group start.
- out_result, out_tag and out_overflow are stable while out_valid && !out_ready. The next group's result may load in the same cycle the current one is consumed.
- Reset mid-group: the partial sum is discarded and no result is emitted.

Decomposition:
- dot_acc_pkg holds:
  - localparam PROD_W = 2*IN_W and SUM_W = PROD_W + clog2(LANES), expressed as functions of the parameters;
  - typedef acc_state_e {IDLE, ACCUM};
  - a function for the signed/unsigned overflow test.
- Sub-module dot_adder_tree (parametrised LANES and width, purely combinational, signed-aware via extension at the leaves), instantiated in S2.

Test Plan:
- Defaults, signed, mask=4'hF, first=last=1, a={1,2,3,4}, b={5,6,7,8}, tag=3 -> out_result=70, out_tag=3, overflow=0, out_valid exactly 3 cycles after acceptance.
- Three back-to-back beats a={1,1,1,1}, b={2,2,2,2} (first on beat 0, last on beat 2) -> single result 24, with no out_valid for beats 0 and 1.
- a lanes = 16'hFFFF, b lanes = 2, mask=4'hF, single beat -> signed gives 48'hFFFF_FFFF_FFF8 (-8); unsigned gives 524280.
- mask=4'b0101, a={10,20,30,40}, b={1,1,1,1} -> 40. Then in_first mid-group after a partial 100 -> restart, and the result excludes 100.
- out_ready held 0 for 5 cycles while streaming three single-beat groups -> in_ready drops, first result held stable, and all three results {70,24,40} delivered in order after release.
- ACC_W=36, unsigned, 16 beats all lanes a=b=16'hFFFF -> out_overflow=1, out_result = exact sum mod 2^36. Also assert reset mid-group -> out_valid stays 0, busy=0 next cycle, and the next group is correct.
